// File: rtl/scalar_muladd_if.sv
// Request/result bundle for the scalar multiply-accumulate unit.
// The master drives the operands and start; the slave returns dout, done and busy.
interface scalar_muladd_if;
  logic         start;
  logic [252:0] a;
  logic [252:0] b;
  logic [252:0] c;
  logic [511:0] dout;
  logic         done;
  logic         busy;

  modport master (output start, output a, output b, output c,
                  input dout, input done, input busy);
  modport slave  (input start, input a, input b, input c,
                  output dout, output done, output busy);
endinterface

// File: rtl/scalar_muladd.sv
// Sequential 253x253-bit multiply-accumulate, dout = a*b + c, unreduced 512-bit result.
// LSB-first shift-and-add: one multiplier bit per cycle, 254 cycles from accept to done.
module scalar_muladd (
  input logic            clk,
  input logic            rst,
  scalar_muladd_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAdd   = 2'd1,
    StFinal = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [511:0] mcand_q, mcand_d;
  logic [511:0] acc_q, acc_d;
  logic [511:0] dout_q, dout_d;
  logic [252:0] mplier_q, mplier_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      acc_q    <= '0;
      dout_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    done_d   = done_q;

    case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (bus.start) begin
          mcand_d  = {259'b0, bus.a};
          mplier_d = bus.b;
          acc_d    = {259'b0, bus.c};
          cnt_d    = 8'd252;
          state_d  = StAdd;
        end
      end
      StAdd: begin
        // Max result is 2^506 - 2^253, so the 512-bit sum never wraps.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == 8'd0) begin
          state_d = StFinal;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StFinal: begin
        dout_d  = acc_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  assign bus.dout = dout_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q != StIdle);

endmodule

// File: doc/scalar_muladd.md
# scalar_muladd

Sequential 253×253-bit scalar multiply-accumulate for the ED25519 datapath. Computes `dout = a*b + c` as an exact, unreduced 512-bit zero-extended result. It is the producer feeding the 512-bit input of the mod-L reducer. Typical use is `S = r + k*s` followed by reduction. It uses an LSB-first shift-and-add with a start/done/busy handshake matching the rest of the scalar pipeline.

## Interface

- No parameters. Widths are fixed: operands are 253 bits and the result is 512 bits.
- `clk` — input — 1 — single clock; all state updates on the rising edge.
- `rst` — input — 1 — reset, asynchronous, active-low.
- `start` — input — 1 — request; sampled only in IDLE.
- `a` — input — 253 — multiplicand; latched when start is accepted.
- `b` — input — 253 — multiplier; latched when start is accepted.
- `c` — input — 253 — addend; latched when start is accepted.
- `dout` — output — 512 — result `a*b + c`, zero-extended; registered.
- `done` — output — 1 — one-cycle completion pulse; registered.
- `busy` — output — 1 — combinational, equal to `state != IDLE`.

## Operation

- Internal registers:
  - `mcand` (512 b)
  - `mplier` (253 b)
  - `acc` (512 b)
  - `cnt` (8 b, counts 252 down to 0)
  - 2-bit `state`: IDLE, ADD, FINAL
- **IDLE**
  - `done <= 0`.
  - If `start`: `mcand <= {259'b0, a}`, `mplier <= b`, `acc <= {259'b0, c}`, `cnt <= 252`, go to ADD.
- **ADD** (one multiplier bit per cycle)
  - If `mplier[0]`: `acc <= acc + mcand`, computed as a 512-bit add.
  - `mcand <= mcand << 1`; `mplier <= mplier >> 1`.
  - If `cnt == 0`, go to FINAL; otherwise `cnt <= cnt - 1`.
- **FINAL**
  - `dout <= acc`, `done <= 1`, go to IDLE.
- Illegal state encoding returns to IDLE.
- Arithmetic bounds:
  - The maximum result is `(2^253-1)^2 + (2^253-1) = 2^506 - 2^253`, so the accumulator never overflows.
  - `dout[511:506]` is always 0.
  - No modular reduction is performed here.
- `start` is ignored while busy. The in-flight operation is unaffected, and the request is neither queued nor acknowledged.
- `a`, `b` and `c` may change freely after the accepting edge.
- `dout` holds its last result until the next FINAL overwrites it. It is valid whenever `done == 1` and remains valid afterwards.

## Timing

- Reset values, applied asynchronously on `rst == 0`:
  - state = IDLE, `done = 0`, `dout = 0`, `busy = 0`
  - `acc`, `mcand`, `mplier` and `cnt` are all 0.
- Accept edge T is the edge where the module is in IDLE and `start == 1`:
  - ADD occupies edges T+1 … T+253 (253 cycles).
  - FINAL is at edge T+254.
  - `done` is high from T+254 to T+255 (exactly one cycle).
- Latency from the accepting edge to the `done` rising is 254 cycles.
- `busy` rises after edge T and falls after edge T+254. `busy` is therefore already low during the `done` cycle.
- Back-to-back operation: `start` held high in the `done` cycle is accepted at edge T+255, and `done` is cleared at that same edge. Throughput is one result per 255 cycles.
- A `start` asserted in the same cycle as `done` counts as a new request. The previous `dout` stays stable until the new FINAL.
- Reset mid-operation aborts immediately. No `done` pulse is produced and `dout` returns to 0. The first `start` after `rst` deasserts is accepted normally.

## Test plan

- `a=2`, `b=3`, `c=0`, start pulse at edge T → `done` at T+254, `dout=6`; `busy` high for exactly 254 cycles.
- `a=b=c=2^253-1` → `dout = 2^506 - 2^253`, and `dout[511:506] = 0`.
- `a=0`, `b=2^253-1`, `c=5` → `dout=5`. Also `a=1`, `b=1`, `c=0` → `dout=1`.
- Start pulses at T+10 and T+200 during an operation with different operands → exactly one `done` at T+254 with the first result. The second start has no effect.
- `start` held high continuously with operands changed every result → `done` pulses at T+254 and T+509, each `dout` matches the operands present at its own accept edge.
- Reset asserted at T+100, then `start` with `a=7`, `b=9`, `c=1` → `dout=0` and `done=0` during reset, then `dout=64` 254 cycles after the new accept. Chained into the reducer with `a=b=L-1`, `c=0`, the reducer output equals 1.
